// File: rtl/fat32_fat_sector_writer_pkg.sv
// Shared FAT32 constants, writer FSM states and a byte-lane helper.
// The MBR/DBR/BPR sector parsers use the same constants.
package fat32_fat_sector_writer_pkg;

  localparam logic [31:0] FAT32_EOC                = 32'h0FFF_FFFF;
  localparam logic [31:0] FAT32_MEDIA              = 32'h0FFF_FFF8;
  localparam int          FAT32_ENTRIES_PER_SECTOR = 128;
  localparam int          FAT32_ENTRY_BYTES        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } wr_state_e;

  // Little-endian byte lane k of a 32-bit FAT entry.
  function automatic logic [7:0] lane_byte(input logic [31:0] v, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = v[7:0];
      2'd1:    b = v[15:8];
      2'd2:    b = v[23:16];
      2'd3:    b = v[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fat32_fat_sector_writer_entry.sv
// Combinational FAT32 entry value for one cluster index, given the root
// cluster and one contiguous file chain.
module fat32_entry_value
  import fat32_fat_sector_writer_pkg::*;
(
  input  logic [31:0] cluster,
  input  logic [31:0] root_cluster,
  input  logic [31:0] start_cluster,
  input  logic [31:0] cluster_count,
  output logic [31:0] value
);

  logic [31:0] last_cluster;
  logic        has_file;

  assign last_cluster = start_cluster + cluster_count - 32'd1;
  assign has_file     = (cluster_count != 32'd0);

  // Root wins over an overlapping file; the link value is not masked to 28 bits.
  always_comb begin
    value = 32'h0000_0000;
    if (cluster == 32'd0) begin
      value = FAT32_MEDIA;
    end else if (cluster == 32'd1) begin
      value = FAT32_EOC;
    end else if (cluster == root_cluster) begin
      value = FAT32_EOC;
    end else if (has_file && (cluster >= start_cluster) && (cluster < last_cluster)) begin
      value = cluster + 32'd1;
    end else if (has_file && (cluster == last_cluster)) begin
      value = FAT32_EOC;
    end else begin
      value = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/fat32_fat_sector_writer.sv
// Generates one 512-byte FAT32 FAT sector and streams it byte by byte with a
// valid/ready handshake; each entry costs one LOAD cycle plus four byte lanes.
module fat32_fat_sector_writer
  import fat32_fat_sector_writer_pkg::*;
#(
  parameter int theSizeofSectors = 512,
  parameter int indexWidth       = 9
) (
  input  logic                  Clock,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [31:0]           fatSectorIndex,
  input  logic [31:0]           RootClusterNumber,
  input  logic [31:0]           fileStartCluster,
  input  logic [31:0]           fileClusterCount,
  output logic                  busy,
  output logic                  done,
  output logic                  byteValid,
  input  logic                  byteReady,
  output logic [7:0]            Byte,
  output logic [indexWidth-1:0] byteAddress
);

  localparam int          LAST_ENTRY_I = theSizeofSectors / FAT32_ENTRY_BYTES - 1;
  localparam logic [6:0]  LAST_ENTRY   = LAST_ENTRY_I[6:0];

  wr_state_e             state_q, state_d;
  logic [6:0]            entry_q, entry_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           value_q, value_d;
  logic [31:0]           sector_q, sector_d;
  logic [31:0]           root_q, root_d;
  logic [31:0]           fstart_q, fstart_d;
  logic [31:0]           fcount_q, fcount_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [7:0]            byte_q, byte_d;
  logic [indexWidth-1:0] addr_q, addr_d;

  logic [31:0] cluster_s;
  logic [31:0] entry_val_s;
  logic        xfer_s;

  assign cluster_s = (sector_q << 7) + {25'd0, entry_q};
  assign xfer_s    = valid_q && byteReady;

  fat32_entry_value u_entry_value (
    .cluster       (cluster_s),
    .root_cluster  (root_q),
    .start_cluster (fstart_q),
    .cluster_count (fcount_q),
    .value         (entry_val_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    lane_d   = lane_q;
    value_d  = value_q;
    sector_d = sector_q;
    root_d   = root_q;
    fstart_d = fstart_q;
    fcount_d = fcount_q;
    byte_d   = byte_q;
    addr_d   = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sector_d = fatSectorIndex;
          root_d   = RootClusterNumber;
          fstart_d = fileStartCluster;
          fcount_d = fileClusterCount;
          entry_d  = 7'd0;
          lane_d   = 2'd0;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        value_d = entry_val_s;
        lane_d  = 2'd0;
        byte_d  = entry_val_s[7:0];
        addr_d  = {entry_q, 2'b00};
        state_d = ST_SEND;
      end
      ST_SEND: begin
        // Byte and address only move on an accepted transfer.
        if (xfer_s) begin
          if (lane_q != 2'd3) begin
            lane_d = lane_q + 2'd1;
            byte_d = lane_byte(value_q, lane_q + 2'd1);
            addr_d = {entry_q, lane_q + 2'd1};
          end else if (entry_q != LAST_ENTRY) begin
            entry_d = entry_q + 7'd1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_SEND);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge Clock) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      entry_q  <= 7'd0;
      lane_q   <= 2'd0;
      value_q  <= 32'd0;
      sector_q <= 32'd0;
      root_q   <= 32'd0;
      fstart_q <= 32'd0;
      fcount_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      byte_q   <= 8'd0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      lane_q   <= lane_d;
      value_q  <= value_d;
      sector_q <= sector_d;
      root_q   <= root_d;
      fstart_q <= fstart_d;
      fcount_q <= fcount_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign byteValid   = valid_q;
  assign Byte        = byte_q;
  assign byteAddress = addr_q;

endmodule

// File: tb/tb_fat32_fat_sector_writer.sv
// Self-checking bench: table vectors plus random sectors, compared against a
// cluster-chain reference model of the FAT sector contents.
module tb_fat32_fat_sector_writer;

  logic        Clock = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [31:0] fatSectorIndex, RootClusterNumber, fileStartCluster, fileClusterCount;
  logic        busy, done, byteValid, byteReady;
  logic [7:0]  Byte;
  logic [8:0]  byteAddress;

  always #5 Clock = ~Clock;

  fat32_fat_sector_writer dut (
    .Clock             (Clock),
    .sys_rst           (sys_rst),
    .start             (start),
    .fatSectorIndex    (fatSectorIndex),
    .RootClusterNumber (RootClusterNumber),
    .fileStartCluster  (fileStartCluster),
    .fileClusterCount  (fileClusterCount),
    .busy              (busy),
    .done              (done),
    .byteValid         (byteValid),
    .byteReady         (byteReady),
    .Byte              (Byte),
    .byteAddress       (byteAddress)
  );

  typedef struct {
    logic [31:0] sector;
    logic [31:0] root;
    logic [31:0] s;
    logic [31:0] cnt;
    int          ready_pct;
    int          mid_start;
    int          chk_n;
    int          chk_entry [3];
    logic [31:0] chk_word  [3];
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the entry is the file chain position, root and reserved entries first.
  function automatic logic [31:0] ref_entry(input logic [31:0] c, input logic [31:0] root,
                                            input logic [31:0] s, input logic [31:0] cnt);
    logic [31:0] off;
    off = c - s;
    if (c == 32'd0) return 32'h0FFF_FFF8;
    if (c == 32'd1 || c == root) return 32'h0FFF_FFFF;
    if (cnt != 32'd0 && c >= s && off < cnt)
      return (off == cnt - 32'd1) ? 32'h0FFF_FFFF : c + 32'd1;
    return 32'h0000_0000;
  endfunction

  function automatic logic [7:0] ref_byte(input vec_t v, input int addr);
    logic [31:0] c, w;
    c = v.sector * 32'd128 + 32'(addr / 4);
    w = ref_entry(c, v.root, v.s, v.cnt);
    return 8'(w >> (8 * (addr % 4)));
  endfunction

  function automatic vec_t mk(input logic [31:0] sector, input logic [31:0] root,
                              input logic [31:0] s, input logic [31:0] cnt,
                              input int pct, input int mid,
                              input int e0, input logic [31:0] w0,
                              input int e1, input logic [31:0] w1,
                              input int e2, input logic [31:0] w2);
    vec_t v;
    v.sector = sector; v.root = root; v.s = s; v.cnt = cnt;
    v.ready_pct = pct; v.mid_start = mid; v.chk_n = 3;
    v.chk_entry[0] = e0; v.chk_word[0] = w0;
    v.chk_entry[1] = e1; v.chk_word[1] = w1;
    v.chk_entry[2] = e2; v.chk_word[2] = w2;
    return v;
  endfunction

  // Runs one sector; rst_addr >= 0 asserts sys_rst when that address is presented.
  task automatic run_vec(input vec_t v, input int rst_addr);
    logic [31:0] got_word [128];
    int          idx, busy_cnt, done_cnt, first_valid, k;
    logic        prev_stall, rdy;
    logic [7:0]  prev_byte;
    logic [8:0]  prev_addr;
    idx = 0; busy_cnt = 0; done_cnt = 0; first_valid = -1; prev_stall = 1'b0;
    prev_byte = 8'd0; prev_addr = 9'd0;
    for (int i = 0; i < 128; i++) got_word[i] = 32'd0;

    @(negedge Clock);
    fatSectorIndex = v.sector; RootClusterNumber = v.root;
    fileStartCluster = v.s; fileClusterCount = v.cnt;
    start = 1'b1; byteReady = 1'b0;
    k = 0;
    forever begin
      @(negedge Clock);
      k++;
      start = 1'b0;
      if (v.mid_start != 0 && k == 100) begin
        start = 1'b1;
        fatSectorIndex = 32'd7; RootClusterNumber = 32'd9;
        fileStartCluster = 32'd0; fileClusterCount = 32'd500;
      end
      if (k == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (k > 1 && !busy) break;
      if (k > 6000) begin
        check("timeout", 32'(k), 32'd0);
        break;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("done_after_last_byte", 32'(idx), 32'd512);
      end
      if (byteValid && first_valid < 0) first_valid = k;
      if (prev_stall) begin
        check("stall_byte_hold", {24'd0, Byte}, {24'd0, prev_byte});
        check("stall_addr_hold", {23'd0, byteAddress}, {23'd0, prev_addr});
      end
      if (rst_addr >= 0 && byteValid && byteAddress == 9'(rst_addr)) begin
        sys_rst = 1'b1;
        @(negedge Clock);
        sys_rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, byteValid}, 32'd0);
        check("rst_byte", {24'd0, Byte}, 32'd0);
        check("rst_addr", {23'd0, byteAddress}, 32'd0);
        for (int j = 0; j < 4; j++) begin
          @(negedge Clock);
          check("rst_no_done", {31'd0, done}, 32'd0);
        end
        return;
      end
      rdy = ($urandom_range(99, 0) < v.ready_pct);
      byteReady = rdy;
      if (byteValid && rdy) begin
        check("addr_order", {23'd0, byteAddress}, 32'(idx));
        check("byte_value", {24'd0, Byte}, {24'd0, ref_byte(v, idx)});
        got_word[idx / 4][8 * (idx % 4) +: 8] = Byte;
        idx++;
      end
      prev_stall = byteValid && !rdy;
      prev_byte  = Byte;
      prev_addr  = byteAddress;
    end
    byteReady = 1'b0;
    check("byte_count", 32'(idx), 32'd512);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("first_valid_latency", 32'(first_valid), 32'd2);
    if (v.ready_pct >= 100) check("busy_cycles", 32'(busy_cnt), 32'd641);
    for (int i = 0; i < v.chk_n; i++)
      check("table_entry", got_word[v.chk_entry[i]], v.chk_word[i]);
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; byteReady = 1'b0;
    fatSectorIndex = 32'd0; RootClusterNumber = 32'd0;
    fileStartCluster = 32'd0; fileClusterCount = 32'd0;

    vecs[0] = mk(32'd0, 32'd2, 32'd5, 32'd3, 100, 0,
                 0, 32'h0FFF_FFF8, 1, 32'h0FFF_FFFF, 7, 32'h0FFF_FFFF);
    vecs[1] = mk(32'd0, 32'd2, 32'd5, 32'd3, 50, 0,
                 2, 32'h0FFF_FFFF, 5, 32'h0000_0006, 6, 32'h0000_0007);
    vecs[2] = mk(32'd1, 32'd2, 32'd120, 32'd20, 100, 0,
                 0, 32'h0000_0081, 11, 32'h0FFF_FFFF, 12, 32'h0000_0000);
    vecs[3] = mk(32'd0, 32'd3, 32'd5, 32'd0, 100, 0,
                 3, 32'h0FFF_FFFF, 2, 32'h0000_0000, 5, 32'h0000_0000);
    vecs[4] = mk(32'd0, 32'd2, 32'd5, 32'd3, 100, 1,
                 5, 32'h0000_0006, 6, 32'h0000_0007, 7, 32'h0FFF_FFFF);
    for (int i = 5; i < 8; i++) begin
      vecs[i] = mk(32'($urandom_range(2, 0)), 32'($urandom_range(300, 2)),
                   32'($urandom_range(300, 2)), 32'($urandom_range(200, 0)),
                   int'($urandom_range(100, 30)), 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
      vecs[i].chk_n = 0;
    end

    repeat (3) @(negedge Clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_valid", {31'd0, byteValid}, 32'd0);
    check("reset_byte", {24'd0, Byte}, 32'd0);
    check("reset_addr", {23'd0, byteAddress}, 32'd0);
    sys_rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], -1);
    run_vec(vecs[0], 200);
    run_vec(vecs[0], -1);
    for (int i = 5; i < 8; i++) run_vec(vecs[i], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
